// File: rtl/mux_arbiter.sv
// N-to-1 registered merge with source tagging; N = 2**NB_SEL sources.
// Define MUX_ARBITER_ROUND_ROBIN_EN for rotating priority; fixed priority (index 0 highest) otherwise.
module mux_arbiter #(
    parameter int BUS_WIDTH = 4,
    parameter int NB_SEL    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [(2**NB_SEL)-1:0]        in_valid,
    input  logic [(2**NB_SEL)*BUS_WIDTH-1:0] in_data,
    output logic [(2**NB_SEL)-1:0]        in_ready,
    output logic                          out_valid,
    output logic [BUS_WIDTH-1:0]          out_data,
    output logic [NB_SEL-1:0]             out_sel,
    input  logic                          out_ready
);

    localparam int N = 2**NB_SEL;

    // Handshake: a word moves on a rising edge only when valid and ready are both 1
    // on that port; valid never waits on ready, and ready never depends on data.
    logic [NB_SEL-1:0] ptr;
    logic [NB_SEL-1:0] grant_idx;
    logic [NB_SEL-1:0] idx;
    logic              grant_vld;
    logic              can_load;
    logic              load;

    // Search starts at ptr and wraps naturally through the NB_SEL-bit adder.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + NB_SEL'(k);
            if (!grant_vld && in_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign load     = grant_vld && can_load && !reset;

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*BUS_WIDTH +: BUS_WIDTH];
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARBITER_ROUND_ROBIN_EN
    // The source just served drops to lowest priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= grant_idx + NB_SEL'(1);
        end
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Registered N-to-1 merge point with a valid/ready handshake on every port. It collects transfers from `2**NB_SEL` independent sources onto one shared bus, so it is the converging counterpart to the `dmux*` fan-out blocks. Each accepted word is tagged with the index of the source that produced it, which lets a downstream `dmux` route responses back. One output register provides full throughput and applies backpressure to all sources.

## Interface
- `BUS_WIDTH`, 4: width of each data word.
- `NB_SEL`, 2: select width. N = `2**NB_SEL` sources.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  N  bit i set: source i presents a word.
- `in_data`  in  N*BUS_WIDTH  packed; source i uses bits `[i*BUS_WIDTH +: BUS_WIDTH]`.
- `in_ready`  out  N  one-hot or zero; bit i set: source i's word is accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  BUS_WIDTH  registered word.
- `out_sel`  out  NB_SEL  index of the source of `out_data`.
- `out_ready`  in  1  sink accepts `out_data` this cycle.

## Operation
- State:
  - output register (`out_valid`, `out_data`, `out_sel`);
  - priority pointer `ptr`, NB_SEL bits.
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0. While `reset`=1, `in_ready`=0.
- `can_load` = `!out_valid || out_ready`.
- Grant: the first i with `in_valid[i]`=1, searching `ptr`, `ptr+1`, … modulo N (wraps from N-1 to 0). No valid input means no grant.
- `in_ready[g]` = `can_load` for the granted g; every other bit is 0. At most one bit is ever set.
- Transfer in, when `in_valid[g] && in_ready[g]`:
  - `out_data` <= word g; `out_sel` <= g; `out_valid` <= 1;
  - `ptr` <= (g+1) mod N.
- Transfer out, when `out_valid && out_ready`: if no transfer in occurs in the same cycle, `out_valid` <= 0. `out_data` and `out_sel` keep their values.
- Drain and load in the same cycle: the new word replaces the old one and `out_valid` stays 1. This sustains one word per cycle.
- While `out_valid && !out_ready`, `out_data` and `out_sel` are held bit-stable and `in_ready` = 0.
- A source that deasserts `in_valid` before it is granted loses nothing. The grant is recomputed every cycle.
- `reset` asserted mid-stream: every register is cleared immediately (asynchronously) and the in-flight word is dropped.

## Timing
- Latency: a word accepted on edge k appears on `out_data` with `out_valid`=1 after edge k, i.e. one cycle.
- `in_ready` is combinational from `in_valid`, `out_ready`, `out_valid` and `ptr`. There is no combinational path from `in_data` to any output.
- `out_valid`, `out_data` and `out_sel` are driven directly from flops.
- Throughput: 1 word per cycle when `out_ready` is held at 1.
- Fairness with round-robin enabled: with all sources valid, every source is granted within N consecutive transfers.

## Configuration
- `MUX_ARBITER_ROUND_ROBIN_EN` defined: `ptr` updates to (g+1) mod N after each transfer in, giving rotating priority.
- Undefined: `ptr` is held at 0. This is fixed priority, where the lowest index wins and starvation of higher indices is permitted.

## Test plan
All scenarios use N=4, BUS_WIDTH=4.
- Reset mid-stream: `out_valid`=1, `out_data`=4'h7, then `reset` pulses for 2 cycles. Required: `out_valid`=0, `out_data`=0, `out_sel`=0 asynchronously, and `in_ready`=4'b0000 throughout the reset.
- Single source: `in_valid`=4'b0100, word 2 = 4'hA, `out_ready`=1. Required: `in_ready`=4'b0100 in the same cycle; the next cycle shows `out_valid`=1, `out_data`=4'hA, `out_sel`=2.
- All sources valid, word i = i+1, `out_ready`=1 for 8 cycles.
  - With the macro: `out_sel` = 0,1,2,3,0,1,2,3 back-to-back with no idle cycles.
  - Without it: `out_sel` = 0 every cycle.
- Backpressure: output holds 4'h3/`out_sel`=1, `out_ready`=0 for 5 cycles, `in_valid`=4'b1111. Required: `in_ready`=4'b0000 and the output is stable for all 5 cycles. When `out_ready` rises, the next source is accepted in that same cycle and the output changes on the following edge.
- Wrap (macro defined): after a grant of source 3, `ptr`=0. Then `in_valid`=4'b1010. Required: source 1 is granted, `ptr` becomes 2, and the next grant goes to source 3.
- Withdrawal: source 3 raises `in_valid` while the output is stalled, then drops it before `out_ready` rises. Required: no word from source 3 ever appears on the output.
